// File: rtl/osd_spi_master.sv
// osd_spi_master: on-chip SPI command source for the OSD port.
// Sends enable/disable bytes and 256-byte line writes, MSB first.
module osd_spi_master #(
   parameter int CLK_DIV = 4,
   parameter int SS_GAP  = 8
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [2:0] cmd_arg,
   input  logic [7:0] data,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       SPI_SCK,
   output logic       SPI_SS3,
   output logic       SPI_DI,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE, SETUP, HIGH, LOW, LOAD, TAIL, GAP, DONE
   } state_t;

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_M1 = 8'(SS_GAP - 1);

   state_t     state;
   logic [7:0] shift;
   logic [7:0] cnt;
   logic [2:0] bits;
   logic [8:0] bytes;
   logic       is_write;
   logic [7:0] cmd_byte;

   assign cmd_byte = cmd_write ? {5'b00100, cmd_arg}
                               : {7'b0100000, cmd_arg[0]};

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         shift      <= '0;
         cnt        <= '0;
         bits       <= '0;
         bytes      <= '0;
         is_write   <= 1'b0;
         SPI_SCK    <= 1'b0;
         SPI_SS3    <= 1'b1;
         SPI_DI     <= 1'b0;
         cmd_ready  <= 1'b1;
         data_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  shift     <= cmd_byte;
                  SPI_DI    <= cmd_byte[7];
                  is_write  <= cmd_write;
                  bytes     <= '0;
                  bits      <= 3'd7;
                  cnt       <= DIV_M1;
                  SPI_SS3   <= 1'b0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP, LOW: begin
               if (cnt == 8'd0) begin
                  SPI_SCK <= 1'b1;
                  cnt     <= DIV_M1;
                  state   <= HIGH;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            HIGH: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  SPI_SCK <= 1'b0;
                  cnt     <= DIV_M1;
                  if (bits != 3'd0) begin
                     bits   <= bits - 3'd1;
                     shift  <= {shift[6:0], 1'b0};
                     SPI_DI <= shift[6];
                     state  <= LOW;
                  end else if (is_write && !bytes[8]) begin
                     data_ready <= 1'b1;
                     state      <= LOAD;
                  end else begin
                     state <= TAIL;
                  end
               end
            end
            // The accepted byte gets a full low phase before its first rise.
            LOAD: begin
               if (data_valid) begin
                  shift      <= data;
                  SPI_DI     <= data[7];
                  bits       <= 3'd7;
                  bytes      <= bytes + 9'd1;
                  cnt        <= DIV_M1;
                  data_ready <= 1'b0;
                  state      <= SETUP;
               end
            end
            TAIL: begin
               if (cnt == 8'd0) begin
                  SPI_SS3 <= 1'b1;
                  cnt     <= GAP_M1;
                  state   <= GAP;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            GAP: begin
               if (cnt == 8'd0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            DONE: begin
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_osd_spi_master.sv
// tb_osd_spi_master: random command/payload traffic against
// a bit-level SPI receiver model of the OSD port.
module tb_osd_spi_master;

   localparam int DIV = 4;
   localparam int GAP = 8;

   typedef logic [7:0] bq_t[$];

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [2:0] cmd_arg;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready;
   logic       SPI_SCK;
   logic       SPI_SS3;
   logic       SPI_DI;
   logic       busy;
   logic       done;

   osd_spi_master #(.CLK_DIV(DIV), .SS_GAP(GAP)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_arg(cmd_arg),
      .data(data), .data_valid(data_valid), .data_ready(data_ready),
      .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3), .SPI_DI(SPI_DI),
      .busy(busy), .done(done)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc++;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // OSD-side receiver: samples DI on every SCK rise while SS3 is low
   logic       sck_q = 1'b0;
   logic       di_q = 1'b0;
   logic [7:0] rx_sh = '0;
   int         rx_n = 0;
   bq_t        rx_q;
   int         rise_t[$];
   int         acc_q[$];
   int         dhs_q[$];
   int         rises, di_chg = -1000, hi_run = 0, last_hi_run;
   int         n_setup_bad, n_hold_bad, n_ss_bad;
   int         n_stall_bad, n_stall_cyc, n_dready;
   int         done_cnt = 0, done_cyc = 0, done_start, first_low;

   always @(negedge clk_sys) begin
      if (!reset_n) begin
         rx_n = 0;
      end else begin
         if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
         if (data_valid && data_ready) dhs_q.push_back(cyc);
         if (data_ready) n_dready++;
         if (SPI_DI !== di_q) di_chg = cyc;
         if (SPI_SCK && !sck_q) begin
            rises++;
            rise_t.push_back(cyc);
            if (cyc - di_chg < DIV) n_setup_bad++;
            if (SPI_SS3) n_ss_bad++;
            rx_sh = {rx_sh[6:0], SPI_DI};
            rx_n++;
            if (rx_n == 8) begin
               rx_q.push_back(rx_sh);
               rx_n = 0;
            end
         end
         if (SPI_SCK && sck_q && SPI_DI !== di_q) n_hold_bad++;
         if (data_ready && !data_valid) begin
            n_stall_cyc++;
            if (SPI_SCK || SPI_SS3) n_stall_bad++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (!SPI_SS3 && first_low < 0) first_low = cyc;
         if (SPI_SS3) hi_run++;
         else begin
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
         end
      end
      sck_q = SPI_SCK;
      di_q  = SPI_DI;
   end

   logic [7:0] pay[256];

   task automatic step();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic clr();
      rx_q.delete();
      rise_t.delete();
      acc_q.delete();
      dhs_q.delete();
      rx_n = 0;
      rises = 0;
      n_setup_bad = 0;
      n_hold_bad = 0;
      n_ss_bad = 0;
      n_stall_bad = 0;
      n_stall_cyc = 0;
      n_dready = 0;
      first_low = -1;
      last_hi_run = 0;
      done_start = done_cnt;
   endtask

   function automatic int spacing_bad(input int skip);
      int bad = 0;
      for (int k = 1; k < rise_t.size(); k++) begin
         int e;
         e = (k % 8 == 0) ? 2 * DIV + 1 : 2 * DIV;
         if (k != skip && rise_t[k] - rise_t[k-1] != e) bad++;
      end
      return bad;
   endfunction

   task automatic wait_done(input string tag, input int lim);
      int s = done_cnt;
      int n = 0;
      while (done_cnt == s && n < lim) begin
         step();
         n++;
      end
      if (n >= lim) chk({tag, ".timeout"}, 0, 1);
   endtask

   task automatic issue(input logic w, input logic [2:0] a);
      int n = 0;
      cmd_write = w;
      cmd_arg   = a;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         step();
         n++;
      end
      if (!cmd_ready) chk("issue.timeout", 0, 1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic check_tx(input string tag, input bq_t exp_q, input int skip);
      int a;
      int last;
      a = (acc_q.size() > 0) ? acc_q[0] : 0;
      last = (rise_t.size() > 0) ? rise_t[rise_t.size()-1] : 0;
      chk($sformatf("%s.accepts", tag), acc_q.size(), 1);
      chk($sformatf("%s.nbytes", tag), rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         chk($sformatf("%s.byte%0d", tag, i), rx_q[i], exp_q[i]);
      chk($sformatf("%s.rises", tag), rises, 8 * exp_q.size());
      chk($sformatf("%s.ss_fall", tag), first_low - a, 1);
      chk($sformatf("%s.first_rise", tag),
          (rise_t.size() > 0) ? rise_t[0] - a : -1, 1 + DIV);
      chk($sformatf("%s.spacing", tag), spacing_bad(skip), 0);
      chk($sformatf("%s.di_setup", tag), n_setup_bad, 0);
      chk($sformatf("%s.di_hold", tag), n_hold_bad, 0);
      chk($sformatf("%s.sck_no_ss", tag), n_ss_bad, 0);
      chk($sformatf("%s.end_to_done", tag), done_cyc - last, 2 * DIV + GAP);
      chk($sformatf("%s.done_pulses", tag), done_cnt - done_start, 1);
      chk($sformatf("%s.ready_after", tag), cmd_ready, 1);
      chk($sformatf("%s.busy_after", tag), busy, 0);
   endtask

   task automatic run_control(input string tag, input logic [2:0] a);
      bq_t e;
      clr();
      data_valid = 1'b1;
      issue(1'b0, a);
      wait_done(tag, 500);
      data_valid = 1'b0;
      e.push_back(8'h40 | {7'd0, a[0]});
      check_tx(tag, e, -1);
      chk({tag, ".total"}, done_cyc - acc_q[0], 1 + DIV + 16 * DIV + GAP);
      chk({tag, ".no_data_ready"}, n_dready, 0);
   endtask

   task automatic run_write(input logic [2:0] line, input int stall_at,
                            input int stall_len, input int abort_at);
      int idx = 0;
      int sl = stall_len;
      int n = 0;
      int aw;
      logic hs;
      aw = $urandom_range(3, 50);
      issue(1'b1, line);
      while (idx < 256 && n < 40000) begin
         if (abort_at >= 0 && idx == abort_at + 1) begin
            if (aw == 0) break;
            aw--;
         end
         if (idx == stall_at && sl > 0) begin
            data_valid = 1'b0;
            sl--;
         end else begin
            data_valid = 1'b1;
            data = pay[idx];
         end
         hs = data_valid && data_ready;
         step();
         n++;
         if (hs) idx++;
      end
      if (n >= 40000) chk("write.drive_timeout", 0, 1);
      if (abort_at >= 0) begin
         data_valid = 1'b0;
      end else begin
         data = 8'hA5;
      end
   endtask

   bq_t exp_w;
   int  d1;

   initial begin
      reset_n = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_arg = 3'b001;
      data = '0;
      data_valid = 1'b0;
      repeat (4) step();
      chk("rst.ss3", SPI_SS3, 1);
      chk("rst.sck", SPI_SCK, 0);
      chk("rst.di", SPI_DI, 0);
      chk("rst.cmd_ready", cmd_ready, 1);
      chk("rst.busy", busy, 0);
      chk("rst.data_ready", data_ready, 0);
      chk("rst.done", done, 0);

      clr();
      d1 = cyc;
      reset_n = 1'b1;
      step();
      cmd_valid = 1'b0;
      wait_done("en_rst", 500);
      chk("en_rst.first_accept", (acc_q.size() > 0) ? acc_q[0] : -1, d1);
      exp_w.delete();
      exp_w.push_back(8'h41);
      check_tx("en_rst", exp_w, -1);
      chk("en_rst.total", done_cyc - acc_q[0], 1 + DIV + 16 * DIV + GAP);

      run_control("dis", 3'b000);
      run_control("ctl_rand", 3'($urandom_range(0, 7)));

      clr();
      for (int i = 0; i < 256; i++) pay[i] = 8'(i);
      run_write(3'd5, -1, 0, -1);
      wait_done("wr5", 30000);
      data_valid = 1'b0;
      exp_w.delete();
      exp_w.push_back(8'h25);
      for (int i = 0; i < 256; i++) exp_w.push_back(pay[i]);
      check_tx("wr5", exp_w, -1);
      chk("wr5.handshakes", dhs_q.size(), 256);

      begin
         logic [2:0] ln;
         int k;
         ln = 3'($urandom_range(0, 7));
         clr();
         for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
         run_write(ln, 17, 100, -1);
         wait_done("stall", 30000);
         data_valid = 1'b0;
         exp_w.delete();
         exp_w.push_back(8'h20 | {5'd0, ln});
         for (int i = 0; i < 256; i++) exp_w.push_back(pay[i]);
         check_tx("stall", exp_w, 8 + 17 * 8);
         chk("stall.handshakes", dhs_q.size(), 256);
         chk("stall.seen", n_stall_cyc > 0, 1);
         chk("stall.lines_idle", n_stall_bad, 0);
         k = 8 + 17 * 8;
         chk("stall.low_phase",
             (rise_t.size() > k && dhs_q.size() > 17) ?
             rise_t[k] - dhs_q[17] : -1, DIV + 1);
      end

      clr();
      for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
      run_write(3'($urandom_range(0, 7)), -1, 0, 40);
      chk("abort.mid_ss3", SPI_SS3, 0);
      chk("abort.mid_busy", busy, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("abort.ss3", SPI_SS3, 1);
      chk("abort.sck", SPI_SCK, 0);
      chk("abort.di", SPI_DI, 0);
      chk("abort.cmd_ready", cmd_ready, 1);
      chk("abort.data_ready", data_ready, 0);
      chk("abort.busy", busy, 0);
      step();
      reset_n = 1'b1;
      step();
      run_control("after_abort", 3'b001);

      clr();
      cmd_write = 1'b0;
      cmd_arg = 3'b001;
      cmd_valid = 1'b1;
      step();
      cmd_arg = 3'b000;
      wait_done("b2b1", 500);
      d1 = done_cyc;
      step();
      cmd_valid = 1'b0;
      wait_done("b2b2", 500);
      chk("b2b.accepts", acc_q.size(), 2);
      chk("b2b.gap_accept", (acc_q.size() > 1) ? acc_q[1] - d1 : -1, 1);
      chk("b2b.ss3_high", last_hi_run >= GAP, 1);
      chk("b2b.nbytes", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         chk("b2b.byte0", rx_q[0], 8'h41);
         chk("b2b.byte1", rx_q[1], 8'h40);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
